// File: rtl/if_id_queue.sv
// IF/ID stage instruction queue: DEPTH-entry FIFO between fetch and decode with
// redirect flush and pre-split MIPS fields. Optional flush counter: IF_ID_FLUSH_CNT_EN.
module if_id_queue #(
  parameter int          PC_W      = 32,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_in,
  input  logic            if_valid_in,
  output logic            if_ready_out,
  input  logic [PC_W-1:0] PC_Counter_output_in,
  input  logic [31:0]     Instruction_memory_in,
  output logic            id_valid_out,
  input  logic            id_ready_in,
  input  logic            flush_jump,
  input  logic            flush_branch,
  output logic [PC_W-1:0] PC_Counter_out,
  output logic [5:0]      Op_code_out,
  output logic [4:0]      IF_ID_Rs_out,
  output logic [4:0]      IF_ID_Rt_out,
  output logic [4:0]      IF_ID_Rd_out,
  output logic [5:0]      Funct_out,
  output logic [15:0]     sign_extend_input_out,
`ifdef IF_ID_FLUSH_CNT_EN
  output logic [15:0]     flush_count_out,
`endif
  output logic [25:0]     Jump_Offset_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, flush;
  logic [31:0]      head_instr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered count, so no ready-to-ready combinational path.
  assign if_ready_out = (count_q < CNT_W'(DEPTH));
  assign id_valid_out = (count_q != '0);
  assign flush        = flush_jump | flush_branch;
  assign push         = if_valid_in & if_ready_out;
  assign pop          = id_valid_out & id_ready_in;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an empty queue masks it, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset_in) begin
      pc_mem_q[wr_ptr_q]    <= PC_Counter_output_in;
      instr_mem_q[wr_ptr_q] <= Instruction_memory_in;
    end
  end

`ifdef IF_ID_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q;

  // Counts only flushes that actually discard entries; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset_in)
      flush_cnt_q <= '0;
    else if (flush && id_valid_out && (flush_cnt_q != 16'hFFFF))
      flush_cnt_q <= flush_cnt_q + 16'd1;
  end

  assign flush_count_out = flush_cnt_q;
`endif

  assign head_instr     = id_valid_out ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign PC_Counter_out = id_valid_out ? pc_mem_q[rd_ptr_q] : '0;

  assign Op_code_out           = head_instr[31:26];
  assign IF_ID_Rs_out          = head_instr[25:21];
  assign IF_ID_Rt_out          = head_instr[20:16];
  assign IF_ID_Rd_out          = head_instr[15:11];
  assign Funct_out             = head_instr[5:0];
  assign sign_extend_input_out = head_instr[15:0];
  assign Jump_Offset_out       = head_instr[25:0];

endmodule
